// File: rtl/fault_pkg.sv
// Shared state encoding and default tuning constants for the voltage-fault response path.
package fault_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_ALERT   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_LOCKOUT = 2'd3
  } fault_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 64;
  localparam int unsigned DEF_MAX_FAULTS      = 3;
  localparam int unsigned DEF_CNT_W           = 8;

endpackage

// File: rtl/fault_timer.sv
// Saturating up-counter with synchronous clear; tc_o flags that the next enabled
// increment will land exactly on TC_VALUE, so the caller can act on that same edge.
module fault_timer #(
  parameter int unsigned TC_VALUE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (TC_VALUE < 1) ? 1 : $clog2(TC_VALUE + 1);
  localparam logic [W-1:0] SAT_VAL  = W'(TC_VALUE);
  localparam logic [W-1:0] LAST_VAL = W'(TC_VALUE - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST_VAL);

endmodule

// File: rtl/fault_response_ctrl.sv
// Debounces the detector's fault flag, interrupts the core, holds it in safe mode
// until acknowledged and clean, and escalates repeated episodes to a sticky lockout.
module fault_response_ctrl
  import fault_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int unsigned MAX_FAULTS      = DEF_MAX_FAULTS,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fault_in,
  input  logic             irq_ack,
  input  logic             clear_lockout,
  output logic             fault_irq,
  output logic             safe_mode,
  output logic             lockout,
  output logic             fault_latched,
  output logic [CNT_W-1:0] fault_count,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fault_state_e     state_q, state_d;
  logic             fault_irq_q, safe_mode_q, lockout_q, fault_latched_q;
  logic             fault_latched_d;
  logic [CNT_W-1:0] fault_count_q, fault_count_d;
  logic [CNT_W-1:0] retry_q, retry_d;

  logic qual_clr, qual_en, qual_tc;
  logic tmr_clr, tmr_en, tmr_tc;
  logic qualify, clean_hit, lock_due;

  fault_timer #(.TC_VALUE(DEBOUNCE_CYCLES)) u_qual_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr_i(qual_clr),
    .en_i (qual_en),
    .tc_o (qual_tc)
  );

  // Shared between the MONITOR clean window and the HOLDOFF window; the FSM
  // clears it on every path into either state, so the two uses never overlap.
  fault_timer #(.TC_VALUE(HOLDOFF_CYCLES)) u_clean_tmr (
    .clk  (clk),
    .rst  (reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  assign lock_due = (MAX_FAULTS != 0) && (32'(retry_q) >= MAX_FAULTS);

  always_comb begin
    state_d         = state_q;
    qual_en         = 1'b0;
    qual_clr        = 1'b1;
    tmr_en          = 1'b0;
    tmr_clr         = 1'b1;
    qualify         = 1'b0;
    clean_hit       = 1'b0;
    fault_latched_d = fault_latched_q;
    fault_count_d   = fault_count_q;
    retry_d         = retry_q;

    unique case (state_q)
      ST_MONITOR: begin
        qual_en   = fault_in;
        qual_clr  = !fault_in;
        tmr_en    = !fault_in;
        tmr_clr   = fault_in;
        qualify   = fault_in && qual_tc;
        clean_hit = !fault_in && tmr_tc;
        if (qualify) begin
          state_d  = ST_ALERT;
          qual_clr = 1'b1;
        end
      end
      ST_ALERT: begin
        if (irq_ack) begin
          state_d = lock_due ? ST_LOCKOUT : ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        tmr_en  = !fault_in;
        tmr_clr = fault_in;
        if (!fault_in && tmr_tc) begin
          state_d = ST_MONITOR;
          tmr_clr = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (clear_lockout) begin
          state_d = ST_MONITOR;
        end
      end
      default: state_d = ST_MONITOR;
    endcase

    if (clear_lockout || clean_hit) begin
      retry_d = '0;
    end
    if (clear_lockout) begin
      fault_latched_d = 1'b0;
    end
    // A qualifying episode on the same edge as a software clear still counts.
    if (qualify) begin
      fault_latched_d = 1'b1;
      if (retry_d != CNT_MAX) begin
        retry_d = retry_d + 1'b1;
      end
      if (fault_count_q != CNT_MAX) begin
        fault_count_d = fault_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_MONITOR;
      fault_irq_q     <= 1'b0;
      safe_mode_q     <= 1'b0;
      lockout_q       <= 1'b0;
      fault_latched_q <= 1'b0;
      fault_count_q   <= '0;
      retry_q         <= '0;
    end else begin
      state_q         <= state_d;
      fault_irq_q     <= (state_d == ST_ALERT);
      safe_mode_q     <= (state_d != ST_MONITOR);
      lockout_q       <= (state_d == ST_LOCKOUT);
      fault_latched_q <= fault_latched_d;
      fault_count_q   <= fault_count_d;
      retry_q         <= retry_d;
    end
  end

  assign fault_irq     = fault_irq_q;
  assign safe_mode     = safe_mode_q;
  assign lockout       = lockout_q;
  assign fault_latched = fault_latched_q;
  assign fault_count   = fault_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fault_response_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_fault_response_ctrl;

  localparam int D = 4;
  localparam int H = 64;
  localparam int M = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       fault_in, irq_ack, clear_lockout;
  logic       fault_irq, safe_mode, lockout, fault_latched;
  logic [7:0] fault_count;
  logic [1:0] state_o;

  logic       f2, a2, c2;
  logic       fault_irq2, safe_mode2, lockout2, fault_latched2;
  logic [7:0] fault_count2;
  logic [1:0] state_o2;

  int errors = 0;
  int checks = 0;

  int m_state, m_high, m_low, m_retry, m_count;
  bit m_latched;

  always #5 clk = ~clk;

  fault_response_ctrl #(
    .DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .MAX_FAULTS(M), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .fault_in(fault_in), .irq_ack(irq_ack),
    .clear_lockout(clear_lockout), .fault_irq(fault_irq), .safe_mode(safe_mode),
    .lockout(lockout), .fault_latched(fault_latched), .fault_count(fault_count),
    .state_o(state_o)
  );

  fault_response_ctrl #(
    .DEBOUNCE_CYCLES(2), .HOLDOFF_CYCLES(4), .MAX_FAULTS(0), .CNT_W(8)
  ) dut_nolock (
    .clk(clk), .reset(reset), .fault_in(f2), .irq_ack(a2),
    .clear_lockout(c2), .fault_irq(fault_irq2), .safe_mode(safe_mode2),
    .lockout(lockout2), .fault_latched(fault_latched2), .fault_count(fault_count2),
    .state_o(state_o2)
  );

  task automatic model_reset();
    m_state = 0; m_high = 0; m_low = 0; m_retry = 0; m_count = 0; m_latched = 0;
  endtask

  // One clock of the specified behaviour, applied to the sampled inputs.
  task automatic model_step(input bit f, input bit a, input bit c);
    bit qual;
    qual = 0;
    case (m_state)
      0: begin
        qual = f && (m_high + 1 >= D);
        if (c) begin m_latched = 0; m_retry = 0; end
        if (f) begin
          m_high++;
          m_low = 0;
        end else begin
          m_high = 0;
          if (m_low < H) m_low++;
          if (m_low >= H) m_retry = 0;
        end
        if (qual) begin
          m_state = 1; m_latched = 1; m_high = 0; m_low = 0;
          if (m_count < 255) m_count++;
          if (m_retry < 255) m_retry++;
        end
      end
      1: begin
        if (c) begin m_latched = 0; m_retry = 0; end
        if (a) begin
          m_state = (M != 0 && m_retry >= M) ? 3 : 2;
          m_low = 0;
        end
      end
      2: begin
        if (c) begin m_latched = 0; m_retry = 0; end
        if (f) m_low = 0;
        else m_low++;
        if (m_low >= H) begin m_state = 0; m_low = 0; m_high = 0; end
      end
      default: begin
        if (c) begin m_state = 0; m_latched = 0; m_retry = 0; m_low = 0; m_high = 0; end
      end
    endcase
  endtask

  task automatic tick(input bit f, input bit a, input bit c);
    fault_in = f; irq_ack = a; clear_lockout = c;
    @(posedge clk);
    model_step(f, a, c);
    #1;
  endtask

  task automatic tick2(input bit f, input bit a, input bit c);
    f2 = f; a2 = a; c2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    checks++;
    if ({fault_irq, safe_mode, lockout, fault_latched} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000", {fault_irq, safe_mode, lockout, fault_latched});
    end
    checks++;
    if (fault_count !== 8'd0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_count_state got count=%0d state=%0d want 0/0", fault_count, state_o);
    end
  endtask

  task automatic test_short_pulse();
    repeat (3) tick(1, 0, 0);
    tick(0, 0, 0);
    checks++;
    if (fault_irq !== 1'b0 || state_o !== 2'd0 || fault_count !== 8'd0) begin
      errors++;
      $display("FAIL short_pulse got irq=%b state=%0d count=%0d want 0/0/0", fault_irq, state_o, fault_count);
    end
  endtask

  task automatic test_qualify_ack();
    int n;
    repeat (3) tick(1, 0, 0);
    checks++;
    if (fault_irq !== 1'b0) begin
      errors++;
      $display("FAIL qualify_early got irq=%b want 0", fault_irq);
    end
    tick(1, 0, 0);
    checks++;
    if ({fault_irq, safe_mode, fault_latched} !== 3'b111 || fault_count !== 8'd1 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL qualify got irq/safe/latched=%b count=%0d state=%0d want 111/1/1",
               {fault_irq, safe_mode, fault_latched}, fault_count, state_o);
    end
    tick(0, 1, 0);
    checks++;
    if (fault_irq !== 1'b0 || state_o !== 2'd2 || safe_mode !== 1'b1) begin
      errors++;
      $display("FAIL ack got irq=%b state=%0d safe=%b want 0/2/1", fault_irq, state_o, safe_mode);
    end
    n = 0;
    while (safe_mode === 1'b1 && n < 200) begin
      tick(0, 0, 0);
      n++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL holdoff_len got=%0d want=64", n);
    end
  endtask

  task automatic test_glitch();
    int n;
    repeat (4) tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (30) tick(0, 0, 0);
    checks++;
    if (safe_mode !== 1'b1 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL glitch_pre got safe=%b state=%0d want 1/2", safe_mode, state_o);
    end
    tick(1, 0, 0);
    n = 1;
    while (safe_mode === 1'b1 && n < 200) begin
      tick(0, 0, 0);
      n++;
    end
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL glitch_len got=%0d want=65", n);
    end
    checks++;
    if (fault_count !== 8'd2 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL glitch_count got count=%0d state=%0d want 2/0", fault_count, state_o);
    end
  endtask

  task automatic test_lockout();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int e = 0; e < 3; e++) begin
      repeat (4) tick(1, 0, 0);
      tick(0, 1, 0);
      if (e < 2) begin
        checks++;
        if (state_o !== 2'd2) begin
          errors++;
          $display("FAIL lockout_ep%0d got state=%0d want 2", e, state_o);
        end
        repeat (64) tick(0, 0, 0);
        repeat (10) tick(0, 0, 0);
      end
    end
    checks++;
    if (state_o !== 2'd3 || lockout !== 1'b1 || safe_mode !== 1'b1) begin
      errors++;
      $display("FAIL lockout_enter got state=%0d lockout=%b safe=%b want 3/1/1", state_o, lockout, safe_mode);
    end
    repeat (10) tick(1, 1, 0);
    checks++;
    if (state_o !== 2'd3 || lockout !== 1'b1) begin
      errors++;
      $display("FAIL lockout_hold got state=%0d lockout=%b want 3/1", state_o, lockout);
    end
    tick(0, 0, 1);
    checks++;
    if (state_o !== 2'd0 || lockout !== 1'b0 || fault_latched !== 1'b0 || safe_mode !== 1'b0 || fault_count !== 8'd3) begin
      errors++;
      $display("FAIL lockout_clear got state=%0d lockout=%b latched=%b safe=%b count=%0d want 0/0/0/0/3",
               state_o, lockout, fault_latched, safe_mode, fault_count);
    end
  endtask

  task automatic test_async_reset();
    repeat (4) tick(1, 0, 0);
    checks++;
    if (state_o !== 2'd1) begin
      errors++;
      $display("FAIL async_pre got state=%0d want 1", state_o);
    end
    fault_in = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({fault_irq, safe_mode, lockout, fault_latched} !== 4'b0000 || fault_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got flags=%b count=%0d want 0000/0",
               {fault_irq, safe_mode, lockout, fault_latched}, fault_count);
    end
    #1 reset = 1'b0;
    model_reset();
    tick(0, 0, 0);
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL async_release got state=%0d want 0", state_o);
    end
  endtask

  task automatic test_random();
    int p;
    int seg_p [4] = '{0, 3, 40, 95};
    for (int s = 0; s < 24; s++) begin
      p = seg_p[$urandom_range(0, 3)];
      for (int i = 0; i < 150; i++) begin
        tick($urandom_range(0, 99) < p, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 2);
        checks++;
        if ({fault_irq, safe_mode, lockout, fault_latched} !==
            {m_state == 1, m_state != 0, m_state == 3, m_latched}) begin
          errors++;
          $display("FAIL rand_flags seg=%0d cyc=%0d got=%b want=%b", s, i,
                   {fault_irq, safe_mode, lockout, fault_latched},
                   {m_state == 1, m_state != 0, m_state == 3, m_latched});
        end
        checks++;
        if (int'(state_o) !== m_state || int'(fault_count) !== m_count) begin
          errors++;
          $display("FAIL rand_state seg=%0d cyc=%0d got state=%0d count=%0d want %0d/%0d",
                   s, i, state_o, fault_count, m_state, m_count);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int want;
    for (int e = 0; e < 300; e++) begin
      repeat (2) tick2(1, 0, 0);
      want = (e + 1 > 255) ? 255 : e + 1;
      checks++;
      if (state_o2 !== 2'd1 || int'(fault_count2) !== want) begin
        errors++;
        $display("FAIL sat_qual ep=%0d got state=%0d count=%0d want 1/%0d", e, state_o2, fault_count2, want);
      end
      tick2(0, 1, 0);
      checks++;
      if (state_o2 !== 2'd2 || lockout2 !== 1'b0) begin
        errors++;
        $display("FAIL sat_ack ep=%0d got state=%0d lockout=%b want 2/0", e, state_o2, lockout2);
      end
      repeat (4) tick2(0, 0, 0);
    end
    checks++;
    if (fault_count2 !== 8'd255 || state_o2 !== 2'd0) begin
      errors++;
      $display("FAIL sat_final got count=%0d state=%0d want 255/0", fault_count2, state_o2);
    end
  endtask

  initial begin
    reset = 1'b1;
    fault_in = 1'b0; irq_ack = 1'b0; clear_lockout = 1'b0;
    f2 = 1'b0; a2 = 1'b0; c2 = 1'b0;
    model_reset();
    test_reset();
    test_short_pulse();
    test_qualify_ack();
    test_glitch();
    test_lockout();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
